// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, two write ports, issue strobe and
// scoreboard outputs. The core drives through master, regfile_mp sits on slave.
interface regfile_mp_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [31:0]       pc_a;
    logic [31:0]       pc_b;
    logic [AW:0]       busy_cnt;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, pc_a, pc_b,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, pc_a, pc_b,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, zero register and busy
// scoreboard. Define REGFILE_TRACE_EN to print a line for every effective write.
module regfile_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             wa_eff, wb_eff, iss_eff;

    assign wa_eff  = bus.wa_en  && (bus.wa_addr  != '0);
    assign wb_eff  = bus.wb_en  && (bus.wb_addr  != '0);
    assign iss_eff = bus.iss_en && (bus.iss_addr != '0);

    // B is applied after A so it wins a same-address conflict; the issue set
    // is applied last so a new producer supersedes a completing one.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wa_eff) begin
            mem_d[bus.wa_addr]  = bus.wa_data;
            busy_d[bus.wa_addr] = 1'b0;
        end
        if (wb_eff) begin
            mem_d[bus.wb_addr]  = bus.wb_data;
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        if (reset) begin
            mem_d  = '{default: '0};
            busy_d = '0;
        end
    end

    always_comb begin
        busy_cnt_d = CW'($countones(busy_d));
    end

    always_ff @(posedge clk) begin
        mem_q      <= mem_d;
        busy_q     <= busy_d;
        busy_cnt_q <= busy_cnt_d;
    end

    assign bus.busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
        logic          wa_hit, wb_hit, iss_hit;

        assign addr    = bus.rd_addr[k*AW +: AW];
        assign wa_hit  = wa_eff  && (bus.wa_addr  == addr);
        assign wb_hit  = wb_eff  && (bus.wb_addr  == addr);
        assign iss_hit = iss_eff && (bus.iss_addr == addr);

        always_comb begin
            if (addr == '0) begin
                word = '0;
            end else if (!reset && wb_hit) begin
                word = bus.wb_data;
            end else if (!reset && wa_hit) begin
                word = bus.wa_data;
            end else begin
                word = mem_q[addr];
            end
        end

        assign bus.rd_data[k*DW +: DW] = word;
        assign bus.rd_busy[k] = busy_q[addr] && !((wa_hit || wb_hit) && !iss_hit);
    end

`ifdef REGFILE_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wa_eff && !(wb_eff && (bus.wb_addr == bus.wa_addr))) begin
                $display("%0t@%h: $%0d <= %h", $time, bus.pc_a, bus.wa_addr, bus.wa_data);
            end
            if (wb_eff) begin
                $display("%0t@%h: $%0d <= %h", $time, bus.pc_b, bus.wb_addr, bus.wb_data);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{bus.pc_a, bus.pc_b};
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// against an array-based reference model; a second NRD=4/DW=16 instance.
module tb_regfile_mp;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    regfile_mp_if #(.DW(32), .AW(5), .NRD(2)) bus ();
    regfile_mp_if #(.DW(16), .AW(5), .NRD(4)) bus4 ();

    regfile_mp #(.DW(32), .AW(5), .NRD(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    regfile_mp #(.DW(16), .AW(5), .NRD(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.rd_addr  = '0;
        bus.wa_en    = 1'b0;
        bus.wa_addr  = '0;
        bus.wa_data  = '0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.pc_a     = 32'h1000;
        bus.pc_b     = 32'h2000;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!reset && bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == a) return bus.wb_data;
        if (!reset && bus.wa_en && bus.wa_addr != 0 && bus.wa_addr == a) return bus.wa_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        bit wrote, issued;
        wrote  = (bus.wa_en && bus.wa_addr != 0 && bus.wa_addr == a) ||
                 (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == a);
        issued = bus.iss_en && bus.iss_addr != 0 && bus.iss_addr == a;
        return m_busy[a] && !(wrote && !issued);
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.wa_en && bus.wa_addr != 0) begin
                m_mem[bus.wa_addr]  = bus.wa_data;
                m_busy[bus.wa_addr] = 1'b0;
            end
            if (bus.wb_en && bus.wb_addr != 0) begin
                m_mem[bus.wb_addr]  = bus.wb_data;
                m_busy[bus.wb_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
    endtask

    // Check combinational outputs against the model, take one clock, check count.
    task automatic step();
        logic [4:0] a0, a1;
        #1;
        a0 = bus.rd_addr[4:0];
        a1 = bus.rd_addr[9:5];
        check("rd_data0", bus.rd_data[31:0],  exp_rd(a0));
        check("rd_data1", bus.rd_data[63:32], exp_rd(a1));
        check("rd_busy0", bus.rd_busy[0], exp_busy(a0));
        check("rd_busy1", bus.rd_busy[1], exp_busy(a1));
        @(posedge clk);
        model_edge();
        #1;
        check("busy_cnt", bus.busy_cnt, m_cnt);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        set_idle();
        bus4.rd_addr = '0;  bus4.wa_en = 1'b0; bus4.wa_addr = '0; bus4.wa_data = '0;
        bus4.wb_en = 1'b0;  bus4.wb_addr = '0; bus4.wb_data = '0;
        bus4.iss_en = 1'b0; bus4.iss_addr = '0; bus4.pc_a = '0; bus4.pc_b = '0;

        // Reset: array contents are unknown beforehand, so no read checks here.
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
        check("rst_cnt", bus.busy_cnt, 0);
        for (int i = 0; i < 32; i += 2) begin
            bus.rd_addr = {5'(i + 1), 5'(i)};
            #1;
            check("rst_rd0", bus.rd_data[31:0], 0);
            check("rst_rd1", bus.rd_data[63:32], 0);
        end

        // Zero register ignores writes.
        bus.rd_addr = '0;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hDEADBEEF;
        #1;
        check("zero_byp", bus.rd_data[31:0], 0);
        step();
        set_idle();
        #1;
        check("zero_arr", bus.rd_data[31:0], 0);

        // Bypass then array read.
        bus.rd_addr = {5'd0, 5'd5};
        bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'h12345678;
        #1;
        check("byp_a", bus.rd_data[31:0], 32'h12345678);
        step();
        bus.wa_en = 1'b0;
        #1;
        check("byp_arr", bus.rd_data[31:0], 32'h12345678);

        // Same-address conflict: B wins.
        bus.rd_addr = {5'd7, 5'd7};
        bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11111111;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h22222222;
        #1;
        check("conf_byp", bus.rd_data[63:32], 32'h22222222);
        step();
        set_idle();
        bus.rd_addr = {5'd0, 5'd7};
        #1;
        check("conf_arr", bus.rd_data[31:0], 32'h22222222);

        // Scoreboard on reg 9.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        step();
        set_idle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        check("sb_busy", bus.rd_busy[0], 1'b1);
        check("sb_cnt1", bus.busy_cnt, 1);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
        #1;
        check("sb_wbclr", bus.rd_busy[0], 1'b0);
        step();
        check("sb_cnt0", bus.busy_cnt, 0);
        bus.wb_en = 1'b0;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h98;
        step();
        set_idle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        check("sb_setwin", bus.rd_busy[0], 1'b1);
        check("sb_cnt_sw", bus.busy_cnt, 1);

        // Reset mid-operation.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        step();
        bus.iss_addr = 5'd4;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h33333333;
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
        set_idle();
        bus.rd_addr = {5'd4, 5'd3};
        #1;
        check("mrst_rd", bus.rd_data[31:0], 0);
        check("mrst_cnt", bus.busy_cnt, 0);
        check("mrst_busy", {30'd0, bus.rd_busy}, 0);
        check("mrst_r9", m_busy[9], 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            reset        = ($urandom_range(0, 63) == 0);
            bus.rd_addr  = {rand_addr(), rand_addr()};
            bus.wa_en    = 1'($urandom_range(0, 1));
            bus.wa_addr  = rand_addr();
            bus.wa_data  = $urandom;
            bus.wb_en    = 1'($urandom_range(0, 1));
            bus.wb_addr  = rand_addr();
            bus.wb_data  = $urandom;
            bus.iss_en   = 1'($urandom_range(0, 1));
            bus.iss_addr = rand_addr();
            bus.pc_a     = $urandom;
            bus.pc_b     = $urandom;
            step();
        end
        reset = 1'b0;
        set_idle();

        // Four-port, 16-bit instance.
        for (int i = 1; i <= 3; i++) begin
            bus4.wa_en   = 1'b1;
            bus4.wa_addr = 5'(i);
            bus4.wa_data = (i == 1) ? 16'hAAAA : (i == 2) ? 16'hBBBB : 16'hCCCC;
            @(posedge clk);
            #1;
        end
        bus4.wa_en   = 1'b0;
        bus4.rd_addr = {5'd0, 5'd3, 5'd2, 5'd1};
        #1;
        check("p4_rd0", bus4.rd_data[15:0],  16'hAAAA);
        check("p4_rd1", bus4.rd_data[31:16], 16'hBBBB);
        check("p4_rd2", bus4.rd_data[47:32], 16'hCCCC);
        check("p4_rd3", bus4.rd_data[63:48], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
